// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demultiplexer with a one-entry holding register per output channel.
// Define DEMUX_AUTO_SEL_EN to replace in_sel with an internal round-robin pointer.
module demux1_4_buf #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ack,
    output logic               frame_start
);

    logic [1:0]       tgt;
    logic             accept;
    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] ptr_q, ptr_d;
    logic       unused_sel;

    assign unused_sel  = ^in_sel;
    assign tgt         = ptr_q;
    assign frame_start = (ptr_q == 2'd0);

    // Strict round-robin: the pointer only advances on an accepted sample.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign tgt         = in_sel;
    assign frame_start = 1'b0;
`endif

    // A full target channel still accepts when its consumer drains it this cycle.
    assign in_ready = ~valid_q[tgt] | out_ack[tgt];
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            valid_d[k] = valid_q[k] & ~out_ack[k];
            data_d[k]  = data_q[k];
            if (accept && (tgt == 2'(k))) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
    end

endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: directed scenarios plus random traffic
// compared against a per-channel occupancy model.
module tb_demux1_4_buf;
    localparam int W = 8;

`ifdef DEMUX_AUTO_SEL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_sel = 2'd0;
    logic [4*W-1:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ack = 4'b0000;
    logic         frame_start;

    demux1_4_buf #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: what each consumer sees, and the round-robin position.
    logic [W-1:0] m_data [4];
    bit           m_full [4];
    int           m_ptr;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_data[k] = '0;
            m_full[k] = 1'b0;
        end
        m_ptr = 0;
    endfunction

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [31:0] m_data_vec();
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = m_data[k];
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input bit v, input logic [W-1:0] d, input logic [1:0] s,
                        input logic [3:0] a, output bit accepted);
        int t;
        bit rdy;
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        out_ack  = a;
        #1;
        t   = AUTO ? m_ptr : int'(s);
        rdy = !m_full[t] || a[t];
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        check("frame_start", {31'd0, frame_start}, {31'd0, (AUTO && m_ptr == 0)});
        @(posedge clk);
        accepted = v && rdy;
        for (int k = 0; k < 4; k++) begin
            if (accepted && k == t) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (a[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (accepted) begin
            m_ptr = (m_ptr + 1) % 4;
            $display("accept ch%0d data %h ack %b", t, d, a);
        end
        #1;
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid_vec()});
        check("out_data", out_data, m_data_vec());
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ack = 4'b0000;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        bit v;
        logic [W-1:0] d;
        logic [1:0] s;
        logic [3:0] a;

        model_reset();
        do_reset();
        check("reset_valid", {28'd0, out_valid}, 32'd0);
        check("reset_data", out_data, 32'd0);

        // Async reset with channel 2 full, asserted between clock edges.
        step(1'b1, 8'h77, 2'd2, 4'b0000, acc);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {28'd0, out_valid}, 32'd0);
        check("async_rst_data", out_data, 32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Routing.
        step(1'b1, 8'hA5, 2'd2, 4'b0000, acc);
`ifndef DEMUX_AUTO_SEL_EN
        check("route_valid", {28'd0, out_valid}, 32'h4);
        check("route_data", {24'd0, out_data[23:16]}, 32'hA5);
`endif
        // Backpressure on channel 1.
        step(1'b1, 8'h3C, 2'd1, 4'b0000, acc);
        step(1'b1, 8'h4D, 2'd1, 4'b0000, acc);
        step(1'b1, 8'h4D, 2'd1, 4'b0010, acc);
`ifndef DEMUX_AUTO_SEL_EN
        check("bp_data", {24'd0, out_data[15:8]}, 32'h4D);
        check("bp_valid", {31'd0, out_valid[1]}, 32'd1);
`endif
        // Simultaneous ack and write on channel 3.
        step(1'b1, 8'h11, 2'd3, 4'b0000, acc);
        step(1'b1, 8'h22, 2'd3, 4'b1000, acc);
`ifndef DEMUX_AUTO_SEL_EN
        check("simul_valid", {31'd0, out_valid[3]}, 32'd1);
        check("simul_data", {24'd0, out_data[31:24]}, 32'h22);
`endif
        // Drain everything, then ack idle channels.
        step(1'b0, 8'h00, 2'd0, 4'b1111, acc);
        step(1'b0, 8'h00, 2'd0, 4'b1111, acc);
        check("idle_ack_valid", {28'd0, out_valid}, 32'd0);

        // Random traffic; a blocked source keeps its sample and select.
        v = 1'b0;
        d = '0;
        s = 2'd0;
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(v && !acc)) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
                s = 2'($urandom);
            end
            a = 4'($urandom) & 4'($urandom);
            step(v, d, s, a, acc);
        end

`ifdef DEMUX_AUTO_SEL_EN
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            #0;
            check("auto_frame_start", {31'd0, frame_start}, {31'd0, (i == 1 || i == 5)});
            step(1'b1, W'(i), 2'd0, 4'b1111, acc);
            check("auto_route_valid", {28'd0, out_valid}, 32'(4'b0001 << ((i - 1) % 4)));
            check("auto_route_data", 32'(out_data >> (((i - 1) % 4) * 8)) & 32'hFF, 32'(i));
        end
`endif

        in_valid = 1'b0;
        out_ack = 4'b0000;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
